// File: rtl/count_sup_limit_pkg.sv
// Shared types and constants for the supremum-bounded count controller.
// Command opcodes, FSM state encoding and the all-ones reset limit.
package count_sup_limit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [1:0] OP_SET_LIMIT = 2'd0;
  localparam logic [1:0] OP_START     = 2'd1;
  localparam logic [1:0] OP_PAUSE     = 2'd2;
  localparam logic [1:0] OP_STOP      = 2'd3;

  // Sliced to WIDTH by the controller so the reset limit is always all ones.
  localparam logic [63:0] LIMIT_ALL_ONES = '1;

endpackage

// File: rtl/count_sup_limit_ctrl_tick_divider.sv
// Prescaler: counts 0..DIVIDE-1 while enabled and flags the terminal cycle.
// Holds its value when disabled; clear returns it to 0.
module tick_divider #(
  parameter int DIVIDE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_sup_limit_ctrl.sv
// Command-driven up-counter bounded by a programmable limit, shown on leds.
// Handshake: a command is taken when cmd_valid && cmd_ready at a rising edge; cmd_ready then drops for one commit cycle.
module count_sup_limit_ctrl
  import count_sup_limit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIVIDE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] leds,
  output logic             busy,
  output logic             done,
  output state_t           fsm_state
);

  localparam logic [WIDTH-1:0] LIMIT_RESET = LIMIT_ALL_ONES[WIDTH-1:0];

  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] limit, limit_n;
  logic             done_n;
  logic             ready_q;
  logic             accept;
  logic             step;
  logic             presc_clear;

  assign accept      = cmd_valid && ready_q;
  assign presc_clear = accept && ((cmd_op == OP_START) || (cmd_op == OP_STOP));

  tick_divider #(.DIVIDE(DIVIDE)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (state == ST_RUN),
    .clear  (presc_clear),
    .tick   (step)
  );

  // An accepted command takes precedence; a coincident step is dropped.
  always_comb begin
    state_n = state;
    count_n = count;
    limit_n = limit;
    done_n  = 1'b0;
    if (accept) begin
      case (cmd_op)
        OP_SET_LIMIT: begin
          limit_n = cmd_data;
          if (cmd_data < count) count_n = '0;
        end
        OP_START: begin
          count_n = '0;
          state_n = ST_RUN;
        end
        OP_STOP: begin
          count_n = '0;
          state_n = ST_IDLE;
        end
        default: begin
          if (state == ST_RUN)         state_n = ST_PAUSED;
          else if (state == ST_PAUSED) state_n = ST_RUN;
        end
      endcase
    end else if (step) begin
      if (count == limit) begin
        done_n = 1'b1;
        if (auto_reload) count_n = '0;
        else             state_n = ST_HOLD;
      end else begin
        count_n = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      limit   <= LIMIT_RESET;
      done    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      count   <= count_n;
      limit   <= limit_n;
      done    <= done_n;
      ready_q <= !accept;
    end
  end

  assign cmd_ready = ready_q;
  assign leds      = count;
  assign busy      = (state == ST_RUN) || (state == ST_PAUSED);
  assign fsm_state = state;

endmodule

// File: doc/count_sup_limit_ctrl.md
# count_sup_limit_ctrl

Command-driven controller that sequences an up-counter bounded by a programmable supremum and presents the count on the board LEDs. It sits between a host/command source and the LED pins and replaces free-running count-to-limit behaviour with start/pause/stop/limit control, a prescaled count rate, and a done indication. The MainTest-style bench drives it with `clock`/`reset` and observes `leds`.

## Interface
- `WIDTH`, 8: count, limit and LED width.
- `DIVIDE`, 4: clock cycles per count step; legal values are 1 and above.
- `clock` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: controller can accept a command. A command is accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` in 2: 0 = SET_LIMIT, 1 = START, 2 = PAUSE (toggle), 3 = STOP.
- `cmd_data` in WIDTH: limit value. Used only by SET_LIMIT.
- `auto_reload` in 1: sampled at each limit hit. When 1, the counter wraps to 0 and keeps running.
- `leds` out WIDTH: current count, registered.
- `busy` out 1: high in RUN and PAUSED.
- `done` out 1: one-cycle pulse when the count step at the limit occurs.

## Operation
- **States**
  - IDLE: count holds 0.
  - RUN: prescaler and count advance.
  - PAUSED: prescaler and count are frozen.
  - HOLD: limit reached with no reload; count holds at the limit.
- **Prescaler**
  - Counts 0..DIVIDE-1 only in RUN.
  - A step occurs on the edge where the prescaler is at DIVIDE-1; the prescaler then returns to 0.
- **Step**
  - If count == limit: pulse `done`. If `auto_reload`, count goes to 0 and the state stays RUN. Otherwise the state goes to HOLD and count stays at the limit.
  - Otherwise count increments by 1.
  - Count never exceeds the limit, so no WIDTH overflow is possible. Limit 2^WIDTH-1 with reload wraps to 0.
- **Commands**
  - START (any state): count = 0, prescaler = 0, go to RUN.
  - STOP (any state): count = 0, prescaler = 0, go to IDLE.
  - PAUSE: RUN goes to PAUSED; PAUSED goes to RUN with the prescaler resuming from its frozen value. Ignored in IDLE and HOLD (accepted, no effect).
  - SET_LIMIT (any state): limit = `cmd_data`; the state is unchanged. If the new limit is below the current count, count is cleared to 0 in the same edge. In HOLD, a new limit above the count does not restart counting; START is required.
- **`cmd_ready`**: deasserts for exactly the one cycle after each accepted command (commit cycle). Otherwise it is high. Back-to-back commands therefore complete at best every 2 cycles.
- **Simultaneous command and step**: the command wins and the step in that cycle is discarded. No `done` pulse occurs in that cycle.
- **Reset values**
  - Registers: count 0, limit 2^WIDTH-1, state IDLE, prescaler 0.
  - Outputs: `leds` 0, `busy` 0, `done` 0, `cmd_ready` 1.
- **Reset mid-operation**: all state is cleared asynchronously. A command presented during reset is not accepted.

## Timing
- Command effects are visible on outputs right after the accepting edge N, i.e. during cycle N+1.
- After START is accepted at edge N, the first increment is at edge N+DIVIDE, and `leds`=1 from then.
- Limit L reached from START: `done` is high in the cycle following edge N+(L+1)·DIVIDE.
- With DIVIDE=1, the count steps every edge. `done` and the wrap to 0 occur on the same edge.
- `done` is registered and lasts exactly 1 cycle. In HOLD, `done` never re-fires.
- `busy` tracks the state with no extra latency (registered state decode).

## Structure
- **Package `count_sup_limit_pkg`**
  - State enum (IDLE, RUN, PAUSED, HOLD).
  - `cmd_op` encodings SET_LIMIT/START/PAUSE/STOP.
  - Reset-limit constant (all ones).
- **Sub-module `tick_divider`**
  - Parameter DIVIDE.
  - Inputs: `clock`, `reset`, `enable`, `clear`.
  - Output: one-cycle `tick`.
  - Frozen when `enable` is 0.
- The FSM, limit register, count register and command handshake live in `count_sup_limit_ctrl`.

## Test plan
- **Reset/default:** hold `reset` for 4 cycles mid-RUN → `leds`=0, `busy`=0, `done`=0, `cmd_ready`=1 immediately. The limit reads back as 255 (START then run 256·DIVIDE cycles → `done` pulse).
- **Basic run, DIVIDE=4:** SET_LIMIT 5, START, `auto_reload`=0 → `leds` 1..5 every 4 cycles. Single `done` 24 cycles after the START edge, then HOLD with `leds`=5, `busy`=0.
- **Auto-reload, DIVIDE=1:** limit 3 → `leds` sequence 1,2,3,0,1… with `done` coincident with each 3→0 transition. Limit 255 wraps 255→0.
- **Pause/resume:** PAUSE while `leds`=2 with the prescaler at 1, wait 10 cycles → `leds` stays 2. PAUSE again → next step after 3 more cycles (DIVIDE=4).
- **Limit change:** limit 10, run to 7, SET_LIMIT 4 → `leds`=0 next cycle and continues to 4. SET_LIMIT 9 at count 3 → count continues to 9.
- **Collisions/handshake:** START accepted on the step edge → step discarded, `leds`=0. A command held valid continuously → accepted every second cycle; `cmd_ready` low in each commit cycle.
